// File: rtl/tug_of_war_if.sv
// Player-facing signal bundle for the tug_of_war game: the two raw
// active-low keys going in, and the lamp field and seven-segment code
// coming out.
interface tug_of_war_if;
  logic       LeftButton;
  logic       RightButton;
  logic [9:0] LEDR;
  logic [6:0] display;

  // Driver side: whoever presses the keys and watches the lamps.
  modport master (
    output LeftButton,
    output RightButton,
    input  LEDR,
    input  display
  );

  // Game side.
  modport slave (
    input  LeftButton,
    input  RightButton,
    output LEDR,
    output display
  );
endinterface

// File: rtl/tug_of_war.sv
// Two-player tug-of-war game on a 9-lamp field.
//
// Each raw key is edge-detected into a one-cycle press pulse. A lone left
// pulse moves the lit lamp toward LEDR[9] and a lone right pulse moves it
// toward LEDR[1]. Pulling off either end wins, which is terminal until
// reset. Simultaneous pulses cancel.
//
// Optional feature, macro TOW_INPUT_SYNC_EN:
//   defined   -> two synchronizer flops per key ahead of the edge detector;
//                a press shows up on the 3rd rising edge.
//   undefined -> the history flop samples the raw key directly;
//                a press shows up on the 1st rising edge.
module tug_of_war (
  input  logic         clock,
  input  logic         reset,
  tug_of_war_if.slave  bus
);

  typedef enum logic [1:0] {
    S_PLAY      = 2'd0,
    S_LEFT_WON  = 2'd1,
    S_RIGHT_WON = 2'd2
  } state_t;

  localparam logic [8:0] POS_CENTER  = 9'b0_0001_0000;  // lamp 5
  localparam logic [6:0] SEG_BLANK   = 7'b111_1111;
  localparam logic [6:0] SEG_TWO     = 7'b010_0100;
  localparam logic [6:0] SEG_ONE     = 7'b111_1001;

  logic left_in;
  logic right_in;

`ifdef TOW_INPUT_SYNC_EN
  logic [1:0] left_sync;
  logic [1:0] right_sync;

  // Two-flop synchronizers; reset to 1 so released keys look idle.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clock) begin
    if (reset) begin
      left_sync  <= 2'b11;
      right_sync <= 2'b11;
    end else begin
      left_sync  <= {left_sync[0], bus.LeftButton};
      right_sync <= {right_sync[0], bus.RightButton};
    end
  end

  assign left_in  = left_sync[1];
  assign right_in = right_sync[1];
`else
  assign left_in  = bus.LeftButton;
  assign right_in = bus.RightButton;
`endif

  logic left_hist;
  logic right_hist;
  logic left_pulse;
  logic right_pulse;

  // History flops for falling-edge detection; reset to released.
  always_ff @(posedge clock) begin
    if (reset) begin
      left_hist  <= 1'b1;
      right_hist <= 1'b1;
    end else begin
      left_hist  <= left_in;
      right_hist <= right_in;
    end
  end

  // One pulse per 1->0 transition; holding the key yields nothing more.
  assign left_pulse  = left_hist & ~left_in;
  assign right_pulse = right_hist & ~right_in;

  state_t     state_q, state_d;
  logic [8:0] pos_q, pos_d;  // one-hot, bit 0 = lamp 1 (LEDR[1])

  // Game state register; reset restarts any game, won or not.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_PLAY;
      pos_q   <= POS_CENTER;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // Next-state logic: lone pulses move or win, paired pulses cancel.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      S_PLAY: begin
        if (left_pulse && !right_pulse) begin
          if (pos_q[8]) begin
            state_d = S_LEFT_WON;
            pos_d   = '0;
          end else begin
            pos_d = pos_q << 1;
          end
        end else if (right_pulse && !left_pulse) begin
          if (pos_q[0]) begin
            state_d = S_RIGHT_WON;
            pos_d   = '0;
          end else begin
            pos_d = pos_q >> 1;
          end
        end
      end
      S_LEFT_WON, S_RIGHT_WON: begin
        pos_d = '0;
      end
      default: begin
        state_d = S_PLAY;
        pos_d   = POS_CENTER;
      end
    endcase
  end

  // Output decode from registered state only; LEDR[0] is never lit.
  always_comb begin
    bus.display = SEG_BLANK;
    case (state_q)
      S_LEFT_WON:  bus.display = SEG_TWO;
      S_RIGHT_WON: bus.display = SEG_ONE;
      default:     bus.display = SEG_BLANK;
    endcase
  end

  assign bus.LEDR = {pos_q, 1'b0};

endmodule

// File: tb/tb_tug_of_war.sv
// Self-checking bench for tug_of_war. The reference model tracks the lamp
// as an integer position 1..9 plus a winner code, and reproduces the input
// delay as a short queue of press events. Works in either configuration of
// TOW_INPUT_SYNC_EN.
module tb_tug_of_war;

`ifdef TOW_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_TWO   = 7'b010_0100;
  localparam logic [6:0] SEG_ONE   = 7'b111_1001;

  logic clock = 1'b0;
  logic reset;

  tug_of_war_if bus ();

  tug_of_war dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int m_pos;          // 1..9 while playing
  int m_win;          // 0 playing, 1 left won, 2 right won
  bit m_prev_l, m_prev_r;
  bit q_l[$];
  bit q_r[$];

  function automatic void model_edge(input logic l, input logic r, input logic rst);
    bit el, er;
    if (rst) begin
      m_pos = 5; m_win = 0; m_prev_l = 1; m_prev_r = 1;
      q_l.delete(); q_r.delete();
      for (int i = 0; i < LAT - 1; i++) begin q_l.push_back(0); q_r.push_back(0); end
      return;
    end
    q_l.push_back(m_prev_l && !l);
    q_r.push_back(m_prev_r && !r);
    m_prev_l = l;
    m_prev_r = r;
    el = q_l.pop_front();
    er = q_r.pop_front();
    if (m_win != 0) return;
    if (el && !er) begin
      if (m_pos == 9) m_win = 1; else m_pos++;
    end else if (er && !el) begin
      if (m_pos == 1) m_win = 2; else m_pos--;
    end
  endfunction

  function automatic logic [9:0] exp_ledr();
    return (m_win != 0) ? 10'h000 : (10'h001 << m_pos);
  endfunction

  function automatic logic [6:0] exp_disp();
    return (m_win == 1) ? SEG_TWO : (m_win == 2) ? SEG_ONE : SEG_BLANK;
  endfunction

  // One clock: drive at the falling edge, model at the rising edge,
  // return at the next falling edge with outputs settled.
  task automatic step(input logic l, input logic r, input logic rst);
    bus.LeftButton  = l;
    bus.RightButton = r;
    reset           = rst;
    @(posedge clock);
    model_edge(l, r, rst);
    @(negedge clock);
  endtask

  task automatic do_reset();
    step(1, 1, 1);
    step(1, 1, 1);
    reset = 0;
  endtask

  task automatic press_left();
    repeat (3) step(0, 1, 0);
    repeat (2) step(1, 1, 0);
  endtask

  task automatic press_right();
    repeat (3) step(1, 0, 0);
    repeat (2) step(1, 1, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.LEDR !== 10'h020) begin
      n_err++; $display("FAIL reset_ledr: got %h want %h", bus.LEDR, 10'h020);
    end
    n_cmp++;
    if (bus.display !== SEG_BLANK) begin
      n_err++; $display("FAIL reset_display: got %b want %b", bus.display, SEG_BLANK);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0);
      n_cmp++;
      if (bus.LEDR !== 10'h020) begin
        n_err++; $display("FAIL idle_no_motion cyc %0d: got %h want %h", i, bus.LEDR, 10'h020);
      end
    end
  endtask

  task automatic test_right_win();
    logic [9:0] want;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      press_right();
      want = (i < 5) ? (10'h020 >> i) : 10'h000;
      n_cmp++;
      if (bus.LEDR !== want) begin
        n_err++; $display("FAIL right_press %0d: got %h want %h", i, bus.LEDR, want);
      end
    end
    n_cmp++;
    if (bus.display !== SEG_ONE) begin
      n_err++; $display("FAIL right_won_display: got %b want %b", bus.display, SEG_ONE);
    end
  endtask

  task automatic test_left_win();
    logic [9:0] want;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      press_left();
      want = (i < 5) ? (10'h020 << i) : 10'h000;
      n_cmp++;
      if (bus.LEDR !== want) begin
        n_err++; $display("FAIL left_press %0d: got %h want %h", i, bus.LEDR, want);
      end
      n_cmp++;
      if (i >= 5 && bus.display !== SEG_TWO) begin
        n_err++; $display("FAIL left_won_display %0d: got %b want %b", i, bus.display, SEG_TWO);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    repeat (20) step(0, 1, 0);
    repeat (3) step(1, 1, 0);
    n_cmp++;
    if (bus.LEDR !== 10'h040) begin
      n_err++; $display("FAIL hold_one_move: got %h want %h", bus.LEDR, 10'h040);
    end
  endtask

  task automatic test_both();
    do_reset();
    repeat (4) step(0, 0, 0);
    repeat (4) step(1, 1, 0);
    n_cmp++;
    if (bus.LEDR !== 10'h020) begin
      n_err++; $display("FAIL both_cancel: got %h want %h", bus.LEDR, 10'h020);
    end
  endtask

  task automatic test_reset_after_win();
    do_reset();
    repeat (5) press_right();
    step(1, 1, 1);
    reset = 0;
    n_cmp++;
    if (bus.LEDR !== 10'h020) begin
      n_err++; $display("FAIL reset_after_win_ledr: got %h want %h", bus.LEDR, 10'h020);
    end
    n_cmp++;
    if (bus.display !== SEG_BLANK) begin
      n_err++; $display("FAIL reset_after_win_display: got %b want %b", bus.display, SEG_BLANK);
    end
  endtask

  task automatic test_latency();
    int edges;
    edges = -1;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 0);
      if (bus.LEDR !== 10'h020) begin
        edges = k;
        break;
      end
    end
    n_cmp++;
    if (edges != LAT) begin
      n_err++; $display("FAIL latency: got %0d edges want %0d (-1 = no change in 10)", edges, LAT);
    end
    n_cmp++;
    if (bus.LEDR !== 10'h040) begin
      n_err++; $display("FAIL latency_ledr: got %h want %h", bus.LEDR, 10'h040);
    end
    repeat (3) step(1, 1, 0);
  endtask

  task automatic test_random();
    logic l, r, rst;
    l = 1; r = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) l = ~l;
      if ($urandom_range(3) == 0) r = ~r;
      rst = ($urandom_range(79) == 0);
      step(l, r, rst);
      n_cmp++;
      if (bus.LEDR !== exp_ledr() || bus.display !== exp_disp()) begin
        n_err++;
        $display("FAIL random cyc %0d: got ledr %h disp %b want ledr %h disp %b",
                 i, bus.LEDR, bus.display, exp_ledr(), exp_disp());
      end
    end
    reset = 0;
  endtask

  initial begin
    bus.LeftButton  = 1;
    bus.RightButton = 1;
    reset           = 1;
    test_reset();
    test_right_win();
    test_left_win();
    test_hold();
    test_both();
    test_reset_after_win();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tug_of_war.md
TUG_OF_WAR -- requirements
Module: tug_of_war

Interface
REQ-001 clock  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-003 LeftButton  input  1  raw left-player key; active-low (0 = pressed); asynchronous to clock.
REQ-004 RightButton  input  1  raw right-player key; active-low (0 = pressed); asynchronous to clock.
REQ-005 LEDR  output  10  playfield lamps; LEDR[9:1] form the 9-lamp field (LEDR[9] leftmost); LEDR[0] SHALL be constant 0.
REQ-006 display  output  7  active-low seven-segment code, bit order {g,f,e,d,c,b,a}.

Function
REQ-007 Each button path SHALL contain two synchronizer flops, then a history flop; a press pulse SHALL be asserted for exactly one cycle when history=1 and synchronized=0 (1->0 transition).
REQ-008 A held button SHALL produce one pulse only; the next pulse requires release (1) then press (0) again.
REQ-009 The game state SHALL be one-hot: exactly one of LEDR[9:1] lit while playing; none lit after a win.
REQ-010 States: PLAY (lamp position 1..9), LEFT_WON, RIGHT_WON.
REQ-011 In PLAY, a left pulse alone SHALL move the lit lamp one position toward LEDR[9]; a right pulse alone SHALL move it one position toward LEDR[1].
REQ-012 Left pulse alone while LEDR[9] lit SHALL enter LEFT_WON; right pulse alone while LEDR[1] lit SHALL enter RIGHT_WON.
REQ-013 Left and right pulses in the same cycle SHALL cancel (no move, no win).
REQ-014 LEFT_WON and RIGHT_WON SHALL be terminal: all pulses ignored, LEDR[9:1]=0, until reset.
REQ-015 display SHALL be 1111111 (blank) in PLAY, 0100100 ("2") in LEFT_WON, 1111001 ("1") in RIGHT_WON.
REQ-016 Latency with synchronizer: LEDR/display SHALL change at the 3rd rising edge after the raw button transitions to 0 (setup met).
REQ-017 Outputs SHALL be registered-state decodes only; no combinational path from buttons to LEDR/display.

Reset
REQ-018 While reset=1 at a rising edge: position SHALL be LEDR[5] (LEDR=10'b0000100000), state PLAY, display=1111111.
REQ-019 Reset SHALL load all synchronizer and history flops with 1 (released) so no pulse is generated on reset release while buttons are up.
REQ-020 Reset SHALL take priority over any simultaneous pulse and SHALL restart a game in progress or a won game identically.

Configuration
REQ-021 Macro TOW_INPUT_SYNC_EN: defined -> two synchronizer flops per button as REQ-007, latency per REQ-016.
REQ-022 TOW_INPUT_SYNC_EN undefined -> synchronizer flops omitted; history flop samples raw input directly; pulse = history & ~raw; LEDR SHALL change at the 1st rising edge after the raw transition.
REQ-023 All other behaviour SHALL be identical in both configurations.

Verification
REQ-024 Reset, both keys up -> LEDR=0x020, display=1111111, no motion for 10 cycles.
REQ-025 After reset, 5 RightButton presses (each 0 for >=3 cycles, released between) -> lamp 5->4->3->2->1, then RIGHT_WON: LEDR=0x000, display=1111001.
REQ-026 After reset, 5 LeftButton presses -> lamp 6,7,8,9, then LEFT_WON: LEDR=0x000, display=0100100; 2 further presses -> no change.
REQ-027 LeftButton held 0 for 20 cycles -> exactly one move (LEDR=0x040).
REQ-028 Both buttons pressed in the same cycle -> LEDR stays 0x020; reset asserted after a win -> LEDR=0x020, display blank on next edge.
REQ-029 Latency check: single press -> LEDR changes on 3rd edge (macro defined) or 1st edge (macro undefined).
